// File: rtl/logic_sweep_ctrl_pkg.sv
// Shared types and constants for the logic sweep controller.
// Holds the FSM state set, sweep geometry and the result bundle.
package logic_sweep_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } sweep_state_t;

    localparam int NUM_VECTORS           = 8;
    localparam int SETTLE_CYCLES_DEFAULT = 2;
    localparam int IDX_W                 = 3;
    localparam int CNT_W                 = 4;

    typedef struct packed {
        logic [NUM_VECTORS-1:0] truth_table;
        logic [NUM_VECTORS-1:0] mismatch;
        logic                   pass;
    } sweep_result_t;

    function automatic sweep_result_t make_result(
        input logic [NUM_VECTORS-1:0] tt,
        input logic [NUM_VECTORS-1:0] exp_tt
    );
        sweep_result_t r;
        r.truth_table = tt;
        r.mismatch    = tt ^ exp_tt;
        r.pass        = ((tt ^ exp_tt) == '0);
        return r;
    endfunction

endpackage

// File: rtl/logic_sweep_ctrl_sweep_timer.sv
// Settle-time counter for the sweep controller.
// Load clears it; count advances it; expire marks the final settle cycle.
module sweep_timer
    import logic_sweep_ctrl_pkg::*;
#(
    parameter int SETTLE_CYCLES = SETTLE_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic i_load,
    input  logic i_count,
    output logic o_expire
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(SETTLE_CYCLES - 1);

    logic [CNT_W-1:0] r_cnt;
    logic             w_at_last;

    assign w_at_last = (r_cnt == LAST);
    assign o_expire  = i_count && w_at_last;

    // settle counter: restart on load, advance while counting, hold at last
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= '0;
        end else if (i_count && !w_at_last) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/logic_sweep_ctrl.sv
// Sweeps all eight {A,B,C} vectors into a combinational unit, samples X
// after a settle delay and compares the gathered truth table to a target.
module logic_sweep_ctrl
    import logic_sweep_ctrl_pkg::*;
#(
    parameter int SETTLE_CYCLES = SETTLE_CYCLES_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] exp_table,
    input  logic       x_in,
    output logic [2:0] abc_out,
    output logic       busy,
    output logic       done,
    output logic [7:0] truth_table,
    output logic [7:0] mismatch,
    output logic       pass
);

    sweep_state_t  r_state;
    sweep_state_t  w_next;
    logic [IDX_W-1:0] r_idx;
    logic [7:0]    r_exp;
    logic [7:0]    r_acc;
    logic [7:0]    w_acc_next;
    sweep_result_t r_res;

    logic w_accept;
    logic w_in_sample;
    logic w_last_vec;
    logic w_step;
    logic w_finish;
    logic w_load;
    logic w_expire;

    assign w_accept    = (r_state == IDLE) && start;
    assign w_in_sample = (r_state == SAMPLE);
    assign w_last_vec  = (r_idx == IDX_W'(NUM_VECTORS - 1));
    assign w_step      = w_in_sample && !w_last_vec;
    assign w_finish    = w_in_sample && w_last_vec;
    assign w_load      = w_accept || w_step;

    sweep_timer #(
        .SETTLE_CYCLES (SETTLE_CYCLES)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .i_load   (w_load),
        .i_count  (r_state == SETTLE),
        .o_expire (w_expire)
    );

    // next-state decode for the sweep sequence
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:    if (start) w_next = SETTLE;
            SETTLE:  if (w_expire) w_next = SAMPLE;
            SAMPLE:  w_next = w_last_vec ? DONE : SETTLE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // accumulator with the current vector's bit replaced by the live sample
    always_comb begin
        w_acc_next        = r_acc;
        w_acc_next[r_idx] = x_in;
    end

    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // vector index: zero on accept, step after each non-final sample
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idx <= '0;
        end else if (w_accept) begin
            r_idx <= '0;
        end else if (w_step) begin
            r_idx <= r_idx + 1'b1;
        end
    end

    // expected table is frozen at accept so later changes are ignored
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_exp <= '0;
        end else if (w_accept) begin
            r_exp <= exp_table;
        end
    end

    // sample accumulator, cleared at the start of every sweep
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc <= '0;
        end else if (w_accept) begin
            r_acc <= '0;
        end else if (w_in_sample) begin
            r_acc <= w_acc_next;
        end
    end

    // published result changes only when a sweep completes
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_res <= '0;
        end else if (w_finish) begin
            r_res <= make_result(w_acc_next, r_exp);
        end
    end

    assign busy        = (r_state == SETTLE) || (r_state == SAMPLE);
    assign done        = (r_state == DONE);
    assign abc_out     = busy ? r_idx : 3'b000;
    assign truth_table = r_res.truth_table;
    assign mismatch    = r_res.mismatch;
    assign pass        = r_res.pass;

endmodule

// File: tb/tb_logic_sweep_ctrl.sv
// Bench for logic_sweep_ctrl: two instances (settle 2 and 1) checked
// every cycle against a sweep-schedule model, plus directed scenarios.
module tb_logic_sweep_ctrl;

    logic       clk;
    logic       rst;
    logic       start_v [2];
    logic [7:0] exp_v   [2];
    logic       x_v     [2];
    logic [2:0] abc_v   [2];
    logic       busy_v  [2];
    logic       done_v  [2];
    logic [7:0] tt_v    [2];
    logic [7:0] mis_v   [2];
    logic       pass_v  [2];
    logic [7:0] lut     [2];

    int n_tests;
    int n_fail;
    bit chk_en;
    int hist [8];

    // model state: sweep progress counted in cycles since accept
    bit         m_act  [2];
    int         m_k    [2];
    bit         m_dn   [2];
    logic [7:0] m_exp  [2];
    logic [7:0] m_acc  [2];
    logic [7:0] m_tt   [2];
    logic [7:0] m_mis  [2];
    bit         m_pass [2];
    logic       s_start [2];
    logic [7:0] s_exp   [2];
    logic       s_x     [2];

    function automatic int scv(input int u);
        return (u == 0) ? 2 : 1;
    endfunction

    assign x_v[0] = lut[0][abc_v[0]];
    assign x_v[1] = lut[1][abc_v[1]];

    logic_sweep_ctrl #(.SETTLE_CYCLES(2)) dut0 (
        .clk(clk), .rst(rst), .start(start_v[0]), .exp_table(exp_v[0]),
        .x_in(x_v[0]), .abc_out(abc_v[0]), .busy(busy_v[0]),
        .done(done_v[0]), .truth_table(tt_v[0]), .mismatch(mis_v[0]),
        .pass(pass_v[0])
    );

    logic_sweep_ctrl #(.SETTLE_CYCLES(1)) dut1 (
        .clk(clk), .rst(rst), .start(start_v[1]), .exp_table(exp_v[1]),
        .x_in(x_v[1]), .abc_out(abc_v[1]), .busy(busy_v[1]),
        .done(done_v[1]), .truth_table(tt_v[1]), .mismatch(mis_v[1]),
        .pass(pass_v[1])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input int u,
                       input logic [31:0] act, input logic [31:0] exp_val);
        n_tests++;
        if (act !== exp_val) begin
            n_fail++;
            $display("FAIL %s u%0d got %0h want %0h at %0t",
                     nm, u, act, exp_val, $time);
        end
    endtask

    task automatic model_clear(input int u);
        m_act[u]  = 0;
        m_k[u]    = 0;
        m_dn[u]   = 0;
        m_exp[u]  = '0;
        m_acc[u]  = '0;
        m_tt[u]   = '0;
        m_mis[u]  = '0;
        m_pass[u] = 0;
    endtask

    task automatic model_step(input int u);
        int L;
        L = scv(u) + 1;
        if (m_dn[u]) begin
            m_dn[u] = 0;
        end else if (m_act[u]) begin
            if (m_k[u] % L == L - 1)
                m_acc[u][m_k[u] / L] = s_x[u];
            m_k[u]++;
            if (m_k[u] == 8 * L) begin
                m_act[u]  = 0;
                m_dn[u]   = 1;
                m_tt[u]   = m_acc[u];
                m_mis[u]  = m_acc[u] ^ m_exp[u];
                m_pass[u] = (m_mis[u] == 8'h00);
            end
        end else if (s_start[u] === 1'b1) begin
            m_act[u] = 1;
            m_k[u]   = 0;
            m_exp[u] = s_exp[u];
            m_acc[u] = '0;
        end
    endtask

    // model advance on each clock edge; reset clears it at once
    initial begin
        for (int u = 0; u < 2; u++) model_clear(u);
        forever begin
            @(posedge clk or posedge rst);
            for (int u = 0; u < 2; u++) begin
                if (rst) model_clear(u);
                else if (clk) model_step(u);
            end
        end
    end

    // compare outputs mid-cycle, then capture inputs for the next edge
    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                for (int u = 0; u < 2; u++) begin
                    int L;
                    L = scv(u) + 1;
                    chk("abc",  u, 32'(abc_v[u]),
                        m_act[u] ? 32'(m_k[u] / L) : 32'd0);
                    chk("busy", u, 32'(busy_v[u]), 32'(m_act[u]));
                    chk("done", u, 32'(done_v[u]), 32'(m_dn[u]));
                    chk("tt",   u, 32'(tt_v[u]),   32'(m_tt[u]));
                    chk("mis",  u, 32'(mis_v[u]),  32'(m_mis[u]));
                    chk("pass", u, 32'(pass_v[u]), 32'(m_pass[u]));
                end
            end
            for (int u = 0; u < 2; u++) begin
                s_start[u] = start_v[u];
                s_exp[u]   = exp_v[u];
                s_x[u]     = x_v[u];
            end
        end
    end

    // one sweep on unit 0; returns at the mid-point of the DONE cycle
    task automatic run_sweep(input logic [7:0] lut_val,
                             input logic [7:0] exp_val,
                             input bit disturb, output int cyc);
        for (int i = 0; i < 8; i++) hist[i] = 0;
        @(posedge clk);
        #1;
        lut[0]     = lut_val;
        exp_v[0]   = exp_val;
        start_v[0] = 1'b1;
        @(posedge clk);
        #1;
        start_v[0] = 1'b0;
        cyc = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (busy_v[0]) hist[abc_v[0]]++;
            if (done_v[0]) break;
            if (cyc > 200) begin
                chk("sweep_timeout", 0, 32'(cyc), 32'd25);
                break;
            end
            if (disturb && cyc == 5) begin
                #1;
                start_v[0] = 1'b1;
                exp_v[0]   = 8'h00;
            end else if (disturb && cyc == 6) begin
                #1;
                start_v[0] = 1'b0;
            end
        end
    endtask

    initial begin
        int cyc;
        int d1;
        int d2;
        int lowc;
        int dn_seen;
        bit hit;
        n_tests = 0;
        n_fail  = 0;
        chk_en  = 0;
        rst     = 1'b1;
        for (int u = 0; u < 2; u++) begin
            start_v[u] = 1'b0;
            exp_v[u]   = 8'h00;
            lut[u]     = 8'h00;
        end
        @(posedge clk);
        #1;
        chk_en = 1;
        chk("reset_outs", 0,
            32'({abc_v[0], busy_v[0], done_v[0], tt_v[0], mis_v[0], pass_v[0]}),
            32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // A|B|C against the matching table
        run_sweep(8'hFE, 8'hFE, 0, cyc);
        chk("or_latency", 0, 32'(cyc), 32'd25);
        chk("or_tt",      0, 32'(tt_v[0]), 32'h0FE);
        chk("or_mis",     0, 32'(mis_v[0]), 32'h000);
        chk("or_pass",    0, 32'(pass_v[0]), 32'd1);
        chk("or_busy_dn", 0, 32'(busy_v[0]), 32'd0);

        // A&B&C against the OR table
        run_sweep(8'h80, 8'hFE, 0, cyc);
        chk("and_tt",   0, 32'(tt_v[0]), 32'h080);
        chk("and_mis",  0, 32'(mis_v[0]), 32'h07E);
        chk("and_pass", 0, 32'(pass_v[0]), 32'd0);

        // A|B|C against all-ones, with vector hold times
        run_sweep(8'hFE, 8'hFF, 0, cyc);
        chk("or1_mis",  0, 32'(mis_v[0]), 32'h001);
        chk("or1_pass", 0, 32'(pass_v[0]), 32'd0);
        for (int i = 0; i < 8; i++)
            chk("hold3", i, 32'(hist[i]), 32'd3);

        // abort with reset while vector 4 is applied
        @(posedge clk);
        #1;
        lut[0]     = 8'hFE;
        exp_v[0]   = 8'hFE;
        start_v[0] = 1'b1;
        @(posedge clk);
        #1;
        start_v[0] = 1'b0;
        hit = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (abc_v[0] == 3'd4) begin
                hit = 1;
                break;
            end
        end
        chk("rst_reach4", 0, 32'(hit), 32'd1);
        @(posedge clk);
        #1;
        chk("rst_pre_abc", 0, 32'(abc_v[0]), 32'd4);
        rst = 1'b1;
        #1;
        chk("rst_now", 0,
            32'({abc_v[0], busy_v[0], done_v[0], tt_v[0], mis_v[0], pass_v[0]}),
            32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        dn_seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done_v[0] || busy_v[0]) dn_seen++;
        end
        chk("rst_no_done", 0, 32'(dn_seen), 32'd0);
        chk("rst_tt_clr",  0, 32'(tt_v[0]), 32'd0);

        // mid-sweep start with another table is ignored
        run_sweep(8'h96, 8'h96, 1, cyc);
        chk("ign_tt",   0, 32'(tt_v[0]), 32'h096);
        chk("ign_mis",  0, 32'(mis_v[0]), 32'h000);
        chk("ign_pass", 0, 32'(pass_v[0]), 32'd1);
        chk("ign_lat",  0, 32'(cyc), 32'd25);

        // back-to-back sweeps on the settle-1 unit
        @(posedge clk);
        #1;
        lut[1]     = 8'h5A;
        exp_v[1]   = 8'h5A;
        start_v[1] = 1'b1;
        d1 = -1;
        d2 = -1;
        lowc = 0;
        for (int i = 0; i < 120; i++) begin
            @(negedge clk);
            if (d1 >= 0 && !busy_v[1]) lowc++;
            if (done_v[1]) begin
                if (d1 < 0) begin
                    d1 = i;
                    chk("b2b_busy_dn", 1, 32'(busy_v[1]), 32'd0);
                end else begin
                    d2 = i;
                    break;
                end
            end
        end
        chk("b2b_gap",  1, 32'(d2 - d1), 32'd18);
        chk("b2b_low",  1, 32'(lowc), 32'd2);
        chk("b2b_pass", 1, 32'(pass_v[1]), 32'd1);
        @(posedge clk);
        #1;
        start_v[1] = 1'b0;

        // random traffic on both units, checked cycle by cycle
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk);
            #1;
            rst = ($urandom_range(0, 399) == 0);
            for (int u = 0; u < 2; u++) begin
                start_v[u] = ($urandom_range(0, 3) != 0);
                exp_v[u]   = 8'($urandom);
                if ($urandom_range(0, 15) == 0) lut[u] = 8'($urandom);
            end
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        start_v[0] = 1'b0;
        start_v[1] = 1'b0;
        repeat (4) @(posedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
